// File: rtl/axi_arbiter.sv
//-----------------------------------------------------------------------------
// axi_arbiter
//
// Two-master, one-slave AXI-lite arbiter. It shares a single SRAM slave
// between the instruction fetch unit (IFU, read-only) and the load/store
// unit (LSU, read/write). One transaction is granted at a time. Payloads pass
// through combinationally; only the grant state is registered.
//
// Build option:
//   ARBITER_RR_EN  defined   -> round-robin between IFU and LSU.
//                  undefined -> fixed LSU priority with an IFU starvation
//                               guard (IFU_MAX_WAIT lost grants, 1..15).
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ifu_ar*/ifu_r*    IFU read address / read data channels
//   lsu_ar*/lsu_r*    LSU read address / read data channels
//   lsu_aw*/lsu_w*    LSU write address / write data channels
//   lsu_b*            LSU write response channel
//   s_*               slave-side read and write channels
//   arb_grant         00 none, 01 IFU read, 10 LSU read, 11 LSU write
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module axi_arbiter #(
    parameter int IFU_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // IFU read
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    // LSU read
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    // LSU write
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    // Slave read
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    // Slave write
    output logic [31:0] s_awaddr,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready,
    // Status
    output logic [1:0]  arb_grant
);

    // The state encoding is the arb_grant encoding, so the grant output is
    // simply the state register.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IFU_RD = 2'b01,
        LSU_RD = 2'b10,
        LSU_WR = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   lsu_req;
    logic   ifu_win;
    logic   grant_new;

    assign lsu_req   = lsu_awvalid || lsu_arvalid;
    assign grant_new = (state == IDLE) && (state_nxt != IDLE);
    assign arb_grant = state;

`ifdef ARBITER_RR_EN
    // rr_last = 1 when the LSU held the most recent grant; reset to LSU so
    // the IFU wins the first tie.
    logic rr_last;

    assign ifu_win = ifu_arvalid && (!lsu_req || rr_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (grant_new) begin
            rr_last <= (state_nxt != IFU_RD);
        end
    end
`else
    localparam logic [3:0] MAX_WAIT = 4'(IFU_MAX_WAIT);

    // Counts LSU grants taken while an IFU read was pending.
    logic [3:0] wait_cnt;

    assign ifu_win = ifu_arvalid && (!lsu_req || (wait_cnt == MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (grant_new) begin
            if (state_nxt == IFU_RD) begin
                wait_cnt <= 4'd0;
            end else if (ifu_arvalid && (wait_cnt != 4'hF)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a grant is held until its response handshake. The master's
    // ready is used directly since it is what gets routed to s_rready/s_bready.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ifu_win) begin
                    state_nxt = IFU_RD;
                end else if (lsu_awvalid) begin
                    state_nxt = LSU_WR;
                end else if (lsu_arvalid) begin
                    state_nxt = LSU_RD;
                end
            end
            IFU_RD: if (s_rvalid && ifu_rready) state_nxt = IDLE;
            LSU_RD: if (s_rvalid && lsu_rready) state_nxt = IDLE;
            LSU_WR: if (s_bvalid && lsu_bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Channel routing
    always_comb begin
        s_araddr    = lsu_araddr;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awaddr    = lsu_awaddr;
        s_awvalid   = 1'b0;
        s_wdata     = lsu_wdata;
        s_wstrb     = lsu_wstrb;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = s_rdata;
        ifu_rresp   = s_rresp;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = s_rdata;
        lsu_rresp   = s_rresp;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = s_bresp;
        case (state)
            IFU_RD: begin
                s_araddr    = ifu_araddr;
                s_arvalid   = ifu_arvalid;
                ifu_arready = s_arready;
                s_rready    = ifu_rready;
                ifu_rvalid  = s_rvalid;
            end
            LSU_RD: begin
                s_arvalid   = lsu_arvalid;
                lsu_arready = s_arready;
                s_rready    = lsu_rready;
                lsu_rvalid  = s_rvalid;
            end
            LSU_WR: begin
                s_awvalid   = lsu_awvalid;
                lsu_awready = s_awready;
                s_wvalid    = lsu_wvalid;
                lsu_wready  = s_wready;
                s_bready    = lsu_bready;
                lsu_bvalid  = s_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
`timescale 1ns/1ps
module tb_axi_arbiter;

    localparam int IFU_MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;  logic ifu_arvalid; logic ifu_arready;
    logic [31:0] ifu_rdata;   logic [1:0] ifu_rresp; logic ifu_rvalid; logic ifu_rready;
    logic [31:0] lsu_araddr;  logic lsu_arvalid; logic lsu_arready;
    logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp; logic lsu_rvalid; logic lsu_rready;
    logic [31:0] lsu_awaddr;  logic lsu_awvalid; logic lsu_awready;
    logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb; logic lsu_wvalid; logic lsu_wready;
    logic [1:0]  lsu_bresp;   logic lsu_bvalid;  logic lsu_bready;
    logic [31:0] s_araddr;    logic s_arvalid;   logic s_arready;
    logic [31:0] s_rdata;     logic [1:0] s_rresp; logic s_rvalid; logic s_rready;
    logic [31:0] s_awaddr;    logic s_awvalid;   logic s_awready;
    logic [31:0] s_wdata;     logic [3:0] s_wstrb; logic s_wvalid; logic s_wready;
    logic [1:0]  s_bresp;     logic s_bvalid;    logic s_bready;
    logic [1:0]  arb_grant;

    always #5 clk = ~clk;

    axi_arbiter #(.IFU_MAX_WAIT(IFU_MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .arb_grant(arb_grant)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: expected grant for the current cycle, lost-grant
    // count for the IFU, and who was granted last.
    int exp_grant;
    int m_wait;
    bit m_lsu_last;

    // Random traffic engine state
    int ifu_ph, lsu_ph, sl_ph, sl_dly;
    bit sl_aw_done, sl_w_done;
    int ifu_left, lsu_left, p_ifu, p_lsu, p_wr, p_rdy;
    int ifu_done, lsu_done;
    bit hs_ifu_ar, hs_ifu_r, hs_lsu_ar, hs_lsu_r, hs_lsu_aw, hs_lsu_w, hs_lsu_b;
    bit hs_s_ar, hs_s_r, hs_s_aw, hs_s_w, hs_s_b;
    int glog[$];
    int prev_grant;

    function automatic bit chance(int p);
        return ($urandom_range(0, 99) < p);
    endfunction

    function automatic logic [11:0] vr_out();
        return {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                lsu_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    endfunction

    task automatic drive_idle();
        ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
        lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0;
        lsu_bready = 0;
        s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
        s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        drive_idle();
        ifu_ph = 0; lsu_ph = 0; sl_ph = 0; sl_dly = 0; sl_aw_done = 0; sl_w_done = 0;
        ifu_done = 0; lsu_done = 0;
        {hs_ifu_ar, hs_ifu_r, hs_lsu_ar, hs_lsu_r, hs_lsu_aw, hs_lsu_w, hs_lsu_b} = '0;
        {hs_s_ar, hs_s_r, hs_s_aw, hs_s_w, hs_s_b} = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        exp_grant = 0; m_wait = 0; m_lsu_last = 1; prev_grant = 0;
        glog.delete();
    endtask

    // Grant rules from the arbitration policy, evaluated on the request set
    // the next rising edge will sample.
    task automatic model_update();
        int nxt;
        bit ifu_req, lsu_req, rel, ifu_wins;
        nxt = exp_grant;
        ifu_req = ifu_arvalid;
        lsu_req = lsu_arvalid || lsu_awvalid;
        rel = 0;
        if (rst) begin
            nxt = 0; m_wait = 0; m_lsu_last = 1;
        end else if (exp_grant == 0) begin
            if (ifu_req || lsu_req) begin
`ifdef ARBITER_RR_EN
                ifu_wins = ifu_req && (!lsu_req || m_lsu_last);
`else
                ifu_wins = ifu_req && (!lsu_req || m_wait >= IFU_MAX_WAIT);
`endif
                if (ifu_wins) begin
                    nxt = 1; m_wait = 0; m_lsu_last = 0;
                end else begin
                    nxt = lsu_awvalid ? 3 : 2;
                    if (ifu_req && m_wait < 15) m_wait++;
                    m_lsu_last = 1;
                end
            end
        end else begin
            case (exp_grant)
                1:       rel = s_rvalid && ifu_rready;
                2:       rel = s_rvalid && lsu_rready;
                default: rel = s_bvalid && lsu_bready;
            endcase
            if (rel) nxt = 0;
        end
        exp_grant = nxt;
    endtask

    task automatic check_routing();
        logic [11:0] exp_v;
        logic g1, g2, g3;
        logic [31:0] exp_ar;
        g1 = (exp_grant == 1); g2 = (exp_grant == 2); g3 = (exp_grant == 3);
        n_assert++;
        if (arb_grant !== 2'(exp_grant)) begin
            n_fail++;
            $display("FAIL stream_grant t=%0t: got %0d expected %0d", $time, arb_grant, exp_grant);
        end
        exp_v = {g1 & s_arready, g1 & s_rvalid, g2 & s_arready, g2 & s_rvalid,
                 g3 & s_awready, g3 & s_wready, g3 & s_bvalid,
                 (g1 & ifu_arvalid) | (g2 & lsu_arvalid),
                 (g1 & ifu_rready) | (g2 & lsu_rready),
                 g3 & lsu_awvalid, g3 & lsu_wvalid, g3 & lsu_bready};
        n_assert++;
        if (vr_out() !== exp_v) begin
            n_fail++;
            $display("FAIL stream_route t=%0t: got %b expected %b", $time, vr_out(), exp_v);
        end
        exp_ar = g1 ? ifu_araddr : lsu_araddr;
        n_assert++;
        if ({s_araddr, s_awaddr, s_wdata, s_wstrb, ifu_rdata, lsu_rdata, ifu_rresp, lsu_rresp, lsu_bresp}
            !== {exp_ar, lsu_awaddr, lsu_wdata, lsu_wstrb, s_rdata, s_rdata, s_rresp, s_rresp, s_bresp}) begin
            n_fail++;
            $display("FAIL stream_payload t=%0t: got araddr %h awaddr %h wdata %h rdata %h expected %h %h %h %h",
                     $time, s_araddr, s_awaddr, s_wdata, ifu_rdata, exp_ar, lsu_awaddr, lsu_wdata, s_rdata);
        end
    endtask

    task automatic step_engine();
        @(negedge clk);
        check_routing();
        if (arb_grant != 2'd0 && prev_grant == 0) glog.push_back(int'(arb_grant));
        prev_grant = int'(arb_grant);
        // IFU master
        if (hs_ifu_r) begin ifu_ph = 0; ifu_done++; end
        if (hs_ifu_ar) begin ifu_arvalid = 0; ifu_ph = 2; end
        if (ifu_ph == 0 && ifu_left > 0 && chance(p_ifu)) begin
            ifu_araddr = $urandom; ifu_arvalid = 1; ifu_ph = 1; ifu_left--;
        end
        ifu_rready = chance(p_rdy);
        // LSU master
        if (hs_lsu_r || hs_lsu_b) begin lsu_ph = 0; lsu_done++; end
        if (hs_lsu_ar) begin lsu_arvalid = 0; lsu_ph = 2; end
        if (hs_lsu_aw) lsu_awvalid = 0;
        if (hs_lsu_w) lsu_wvalid = 0;
        if (lsu_ph == 3 && !lsu_awvalid && !lsu_wvalid) lsu_ph = 4;
        if (lsu_ph == 0 && lsu_left > 0 && chance(p_lsu)) begin
            lsu_left--;
            if (chance(p_wr)) begin
                lsu_awaddr = $urandom; lsu_wdata = $urandom; lsu_wstrb = 4'($urandom);
                lsu_awvalid = 1; lsu_wvalid = 1; lsu_ph = 3;
            end else begin
                lsu_araddr = $urandom; lsu_arvalid = 1; lsu_ph = 1;
            end
        end
        lsu_rready = chance(p_rdy);
        lsu_bready = chance(p_rdy);
        // Slave
        if (hs_s_ar) begin sl_ph = 1; sl_dly = $urandom_range(0, 3); end
        if (hs_s_aw) sl_aw_done = 1;
        if (hs_s_w) sl_w_done = 1;
        if (sl_aw_done && sl_w_done) begin
            sl_aw_done = 0; sl_w_done = 0; sl_ph = 4; sl_dly = $urandom_range(0, 3);
        end
        if (hs_s_r || hs_s_b) begin s_rvalid = 0; s_bvalid = 0; sl_ph = 0; end
        if (sl_ph == 1 || sl_ph == 4) begin
            if (sl_dly == 0) begin
                if (sl_ph == 1) begin
                    s_rvalid = 1; s_rdata = $urandom; s_rresp = 2'($urandom); sl_ph = 2;
                end else begin
                    s_bvalid = 1; s_bresp = 2'($urandom); sl_ph = 5;
                end
            end else begin
                sl_dly--;
            end
        end
        s_arready = (sl_ph == 0) && chance(p_rdy);
        s_awready = (sl_ph == 0) && !sl_aw_done && chance(p_rdy);
        s_wready  = (sl_ph == 0) && !sl_w_done && chance(p_rdy);
        #1;
        hs_ifu_ar = ifu_arvalid && ifu_arready;  hs_ifu_r = ifu_rvalid && ifu_rready;
        hs_lsu_ar = lsu_arvalid && lsu_arready;  hs_lsu_r = lsu_rvalid && lsu_rready;
        hs_lsu_aw = lsu_awvalid && lsu_awready;  hs_lsu_w = lsu_wvalid && lsu_wready;
        hs_lsu_b  = lsu_bvalid && lsu_bready;
        hs_s_ar = s_arvalid && s_arready;  hs_s_r = s_rvalid && s_rready;
        hs_s_aw = s_awvalid && s_awready;  hs_s_w = s_wvalid && s_wready;
        hs_s_b  = s_bvalid && s_bready;
        model_update();
    endtask

    task automatic run_engine(input int budget, input string name);
        int cyc;
        bit done;
        cyc = 0; done = 0;
        while (!done && cyc < budget) begin
            step_engine();
            cyc++;
            done = (ifu_left == 0 && lsu_left == 0 && ifu_ph == 0 && lsu_ph == 0 &&
                    sl_ph == 0 && exp_grant == 0);
        end
        step_engine();
        n_assert++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: traffic still pending after %0d cycles, required completion", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        drive_idle();
        ifu_arvalid = 1; lsu_awvalid = 1; lsu_wvalid = 1; s_rvalid = 1; s_bvalid = 1;
        ifu_rready = 1; lsu_bready = 1; s_arready = 1; s_wready = 1; s_awready = 1;
        repeat (3) @(negedge clk);
        n_assert++;
        if (arb_grant !== 2'b00) begin
            n_fail++; $display("FAIL reset_grant: got %b expected 00", arb_grant);
        end
        n_assert++;
        if (vr_out() !== 12'h000) begin
            n_fail++; $display("FAIL reset_vr: got %b expected all zero", vr_out());
        end
        drive_idle();
        rst = 0;
        @(negedge clk);
        n_assert++;
        if (arb_grant !== 2'b00) begin
            n_fail++; $display("FAIL idle_no_req: got %b expected 00", arb_grant);
        end
    endtask

    task automatic test_ifu_read();
        int d;
        @(negedge clk);
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1; ifu_rready = 1; s_arready = 1;
        #1;
        n_assert++;
        if (arb_grant !== 2'b00 || s_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL ifu_rd_latency: got grant %b s_arvalid %b expected 00 0", arb_grant, s_arvalid);
        end
        @(negedge clk);
        n_assert++;
        if (arb_grant !== 2'b01) begin
            n_fail++; $display("FAIL ifu_rd_grant: got %b expected 01", arb_grant);
        end
        n_assert++;
        if ({s_arvalid, ifu_arready, lsu_arready, lsu_rvalid, s_awvalid, s_araddr} !== {5'b11000, 32'h8000_0000}) begin
            n_fail++; $display("FAIL ifu_rd_ar: got %b addr %h expected 11000 addr 80000000",
                               {s_arvalid, ifu_arready, lsu_arready, lsu_rvalid, s_awvalid}, s_araddr);
        end
        ifu_arvalid = 0; s_arready = 0;
        d = $urandom_range(1, 4);
        repeat (d) begin
            @(negedge clk);
            n_assert++;
            if (arb_grant !== 2'b01 || ifu_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL ifu_rd_hold: got grant %b rvalid %b expected 01 0", arb_grant, ifu_rvalid);
            end
        end
        s_rvalid = 1; s_rdata = 32'h0000_0013; s_rresp = 2'b00;
        #1;
        n_assert++;
        if ({ifu_rvalid, ifu_rdata, ifu_rresp, lsu_rvalid, s_rready} !== {1'b1, 32'h13, 2'b00, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL ifu_rd_resp: got rvalid %b rdata %h lsu_rvalid %b s_rready %b expected 1 00000013 0 1",
                               ifu_rvalid, ifu_rdata, lsu_rvalid, s_rready);
        end
        @(negedge clk);
        s_rvalid = 0;
        #1;
        n_assert++;
        if (arb_grant !== 2'b00 || vr_out() !== 12'h000) begin
            n_fail++; $display("FAIL ifu_rd_release: got grant %b vr %b expected 00 zero", arb_grant, vr_out());
        end
        drive_idle();
    endtask

    task automatic test_write();
        @(negedge clk);
        lsu_awaddr = 32'h8000_0100; lsu_awvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'h3;
        lsu_wvalid = 1; lsu_bready = 1;
        lsu_araddr = 32'h8000_0200; lsu_arvalid = 1;
        ifu_araddr = 32'h8000_0300; ifu_arvalid = 1;
        s_awready = 1; s_wready = 1; s_arready = 1;
        @(negedge clk);
        n_assert++;
        if (arb_grant !== 2'b11) begin
            n_fail++; $display("FAIL wr_grant: got %b expected 11", arb_grant);
        end
        n_assert++;
        if ({s_awvalid, lsu_awready, s_wvalid, lsu_wready, s_arvalid, ifu_arready, lsu_arready} !== 7'b1111000 ||
            s_awaddr !== 32'h8000_0100 || s_wdata !== 32'hDEAD_BEEF || s_wstrb !== 4'h3) begin
            n_fail++; $display("FAIL wr_route: got %b awaddr %h wdata %h wstrb %h expected 1111000 80000100 deadbeef 3",
                               {s_awvalid, lsu_awready, s_wvalid, lsu_wready, s_arvalid, ifu_arready, lsu_arready},
                               s_awaddr, s_wdata, s_wstrb);
        end
        lsu_awvalid = 0; lsu_wvalid = 0; s_awready = 0; s_wready = 0;
        repeat (2) begin
            @(negedge clk);
            n_assert++;
            if (arb_grant !== 2'b11 || ifu_arready !== 1'b0 || lsu_bvalid !== 1'b0 || s_arvalid !== 1'b0) begin
                n_fail++; $display("FAIL wr_hold: got grant %b ifu_arready %b bvalid %b s_arvalid %b expected 11 0 0 0",
                                   arb_grant, ifu_arready, lsu_bvalid, s_arvalid);
            end
        end
        s_bvalid = 1; s_bresp = 2'b00;
        #1;
        n_assert++;
        if ({lsu_bvalid, lsu_bresp, s_bready, ifu_arready} !== 5'b10010) begin
            n_fail++; $display("FAIL wr_bresp: got %b expected 10010", {lsu_bvalid, lsu_bresp, s_bready, ifu_arready});
        end
        @(negedge clk);
        n_assert++;
        if (arb_grant !== 2'b00) begin
            n_fail++; $display("FAIL wr_release: got %b expected 00", arb_grant);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        @(negedge clk);
        lsu_araddr = 32'h8000_0040; lsu_arvalid = 1; lsu_rready = 1; s_arready = 1;
        @(negedge clk);
        n_assert++;
        if (arb_grant !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_grant: got %b expected 10", arb_grant);
        end
        lsu_arvalid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        n_assert++;
        if (arb_grant !== 2'b00 || vr_out() !== 12'h000) begin
            n_fail++; $display("FAIL rstmid_idle: got grant %b vr %b expected 00 zero", arb_grant, vr_out());
        end
        rst = 0;
        s_rvalid = 1;
        #1;
        n_assert++;
        if (lsu_rvalid !== 1'b0 || s_rready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_gate: got lsu_rvalid %b s_rready %b expected 0 0", lsu_rvalid, s_rready);
        end
        s_rvalid = 0;
        ifu_araddr = 32'h8000_0080; ifu_arvalid = 1; ifu_rready = 1;
        @(negedge clk);
        n_assert++;
        if (arb_grant !== 2'b01 || s_araddr !== 32'h8000_0080) begin
            n_fail++; $display("FAIL rstmid_regrant: got %b addr %h expected 01 80000080", arb_grant, s_araddr);
        end
        ifu_arvalid = 0;
        rd = $urandom;
        s_rvalid = 1; s_rdata = rd;
        #1;
        n_assert++;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== rd) begin
            n_fail++; $display("FAIL rstmid_resp: got %b %h expected 1 %h", ifu_rvalid, ifu_rdata, rd);
        end
        @(negedge clk);
        drive_idle();
        n_assert++;
        if (arb_grant !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_release: got %b expected 00", arb_grant);
        end
    endtask

    task automatic test_priority();
        int e0, e1;
        do_reset();
        ifu_left = 1; lsu_left = 1; p_ifu = 100; p_lsu = 100; p_wr = 0; p_rdy = 100;
        run_engine(200, "priority");
`ifdef ARBITER_RR_EN
        e0 = 1; e1 = 2;
`else
        e0 = 2; e1 = 1;
`endif
        n_assert++;
        if (glog.size() != 2 || glog[0] != e0 || glog[1] != e1) begin
            n_fail++; $display("FAIL priority_order: got %p expected '{%0d, %0d}", glog, e0, e1);
        end
    endtask

`ifndef ARBITER_RR_EN
    task automatic test_starvation();
        int exp_seq[$];
        exp_seq = '{2, 2, 2, 2, 1, 2, 2};
        do_reset();
        for (int round = 0; round < 2; round++) begin
            glog.delete();
            ifu_left = 1; lsu_left = 6; p_ifu = 100; p_lsu = 100; p_wr = 0; p_rdy = 100;
            run_engine(400, "starve");
            n_assert++;
            if (glog != exp_seq) begin
                n_fail++; $display("FAIL starve_round%0d: got %p expected %p", round, glog, exp_seq);
            end
        end
    endtask
`else
    task automatic test_rr_alternate();
        int exp_seq[$];
        exp_seq = '{1, 2, 1, 2, 1, 2};
        do_reset();
        ifu_left = 3; lsu_left = 3; p_ifu = 100; p_lsu = 100; p_wr = 0; p_rdy = 100;
        run_engine(400, "rr");
        n_assert++;
        if (glog != exp_seq) begin
            n_fail++; $display("FAIL rr_alternate: got %p expected %p", glog, exp_seq);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        ifu_left = 30; lsu_left = 30; p_ifu = 40; p_lsu = 50; p_wr = 40; p_rdy = 60;
        run_engine(5000, "random");
        n_assert++;
        if (ifu_done != 30 || lsu_done != 30) begin
            n_fail++; $display("FAIL random_done: got ifu %0d lsu %0d expected 30 30", ifu_done, lsu_done);
        end
    endtask

    initial begin
        rst = 1;
        drive_idle();
        test_reset();
        test_ifu_read();
        test_write();
        test_reset_mid();
        test_priority();
`ifndef ARBITER_RR_EN
        test_starvation();
`else
        test_rr_alternate();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
